// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives register write enables and bubble controls.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ldUseHaz,
  input  logic        branchTaken,
  input  logic        memReq,
  input  logic        memReady,
  input  logic        mdStart,
  input  logic        mdDone,
  output logic        PCwrite,
  output logic        IF_IDwrite,
  output logic        ID_EXwrite,
  output logic        EX_MEMwrite,
  output logic        IF_IDflush,
  output logic        ID_EXflush,
  output logic        EX_MEMflush,
  output logic [1:0]  state,
  output logic        memErr,
  output logic [31:0] stallCnt,
  output logic [31:0] flushCnt
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_MDWAIT  = 2'd2;
  localparam logic [1:0] ST_HALT    = 2'd3;

  // Control bundle: {PC, IF/ID, ID/EX, EX/MEM write, IF/ID, ID/EX, EX/MEM flush}
  localparam logic [6:0] CTL_RUN    = 7'b1111_000;
  localparam logic [6:0] CTL_FREEZE = 7'b0000_000;
  localparam logic [6:0] CTL_MD     = 7'b0001_001;
  localparam logic [6:0] CTL_BR     = 7'b1111_110;
  localparam logic [6:0] CTL_LU     = 7'b0011_010;
  localparam logic [6:0] CTL_RST    = 7'b0000_111;

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] ONE_C     = {{(TO_W-1){1'b0}}, 1'b1};

  logic [1:0]      state_r, state_nxt_s;
  logic [TO_W-1:0] wait_cnt_r, wait_nxt_s;
  logic            mem_err_r, err_nxt_s;
  logic [6:0]      ctl_s, ctl_out_s;

  // Branch outranks load-use: the stalled ID instruction is being discarded anyway.
  function automatic logic [6:0] run_ctl(input logic md_start, input logic br, input logic ld_use);
    logic [6:0] c;
    if (md_start) begin
      c = CTL_MD;
    end else if (br) begin
      c = CTL_BR;
    end else if (ld_use) begin
      c = CTL_LU;
    end else begin
      c = CTL_RUN;
    end
    return c;
  endfunction

  // Next-state, wait counter and Mealy control decode
  always_comb begin
    ctl_s       = CTL_RUN;
    state_nxt_s = state_r;
    wait_nxt_s  = wait_cnt_r;
    err_nxt_s   = mem_err_r;
    case (state_r)
      ST_RUN: begin
        if (memReq && !memReady) begin
          ctl_s       = CTL_FREEZE;
          state_nxt_s = ST_MEMWAIT;
          wait_nxt_s  = ONE_C;
        end else begin
          ctl_s       = run_ctl(mdStart, branchTaken, ldUseHaz);
          state_nxt_s = mdStart ? ST_MDWAIT : ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (memReady) begin
          ctl_s       = run_ctl(mdStart, branchTaken, ldUseHaz);
          state_nxt_s = mdStart ? ST_MDWAIT : ST_RUN;
          wait_nxt_s  = '0;
        end else if (wait_cnt_r == TIMEOUT_C) begin
          ctl_s       = CTL_FREEZE;
          state_nxt_s = ST_HALT;
          err_nxt_s   = 1'b1;
        end else begin
          ctl_s       = CTL_FREEZE;
          wait_nxt_s  = wait_cnt_r + ONE_C;
        end
      end
      ST_MDWAIT: begin
        if (mdDone) begin
          ctl_s       = CTL_RUN;
          state_nxt_s = ST_RUN;
        end else begin
          ctl_s       = CTL_MD;
        end
      end
      ST_HALT: begin
        ctl_s = CTL_FREEZE;
      end
      default: begin
        ctl_s       = CTL_FREEZE;
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // While reset is held the pipeline is filled with bubbles
  always_comb begin
    if (reset) begin
      ctl_out_s = CTL_RST;
    end else begin
      ctl_out_s = ctl_s;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= '0;
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      mem_err_r  <= err_nxt_s;
    end
  end

  assign {PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite,
          IF_IDflush, ID_EXflush, EX_MEMflush} = ctl_out_s;
  assign state  = state_r;
  assign memErr = mem_err_r;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_r, flush_cnt_r;

  // IF/ID flush outside reset only ever comes from a taken branch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r <= PCwrite    ? stall_cnt_r : stall_cnt_r + 32'd1;
      flush_cnt_r <= IF_IDflush ? flush_cnt_r + 32'd1 : flush_cnt_r;
    end
  end

  assign stallCnt = stall_cnt_r;
  assign flushCnt = flush_cnt_r;
`else
  assign stallCnt = 32'd0;
  assign flushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expectations, a monitor compares.
module tb_pipe_ctrl;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ldUseHaz = 1'b0, branchTaken = 1'b0, memReq = 1'b0, memReady = 1'b0;
  logic mdStart = 1'b0, mdDone = 1'b0;
  logic PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite;
  logic IF_IDflush, ID_EXflush, EX_MEMflush;
  logic [1:0] state;
  logic memErr;
  logic [31:0] stallCnt, flushCnt;

  pipe_ctrl #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .reset(reset), .ldUseHaz(ldUseHaz), .branchTaken(branchTaken),
    .memReq(memReq), .memReady(memReady), .mdStart(mdStart), .mdDone(mdDone),
    .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite), .ID_EXwrite(ID_EXwrite),
    .EX_MEMwrite(EX_MEMwrite), .IF_IDflush(IF_IDflush), .ID_EXflush(ID_EXflush),
    .EX_MEMflush(EX_MEMflush), .state(state), .memErr(memErr),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [6:0] ctl;
    logic [1:0] st;
    logic       err;
    int         stl;
    int         fl;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // {PC, IF/ID, ID/EX, EX/MEM write, IF/ID, ID/EX, EX/MEM flush}
  localparam logic [6:0] RUN_C = 7'b1111_000;
  localparam logic [6:0] FRZ_C = 7'b0000_000;
  localparam logic [6:0] MD_C  = 7'b0001_001;
  localparam logic [6:0] BR_C  = 7'b1111_110;
  localparam logic [6:0] LU_C  = 7'b0011_010;
  localparam logic [6:0] RST_C = 7'b0000_111;

  logic [6:0] act_ctl;
  assign act_ctl = {PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, IF_IDflush, ID_EXflush, EX_MEMflush};

  // Monitor: compares DUT outputs against the oldest expectation each negedge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] es, ef;
      e = sb_q.pop_front();
      checks++;
      if (act_ctl !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl: got %b expected %b", e.nm, act_ctl, e.ctl);
      end
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", e.nm, state, e.st);
      end
      checks++;
      if (memErr !== e.err) begin
        errors++;
        $display("FAIL %s memErr: got %b expected %b", e.nm, memErr, e.err);
      end
      if (e.stl >= 0) begin
        es = PERF ? 32'(e.stl) : 32'd0;
        checks++;
        if (stallCnt !== es) begin
          errors++;
          $display("FAIL %s stallCnt: got %0d expected %0d", e.nm, stallCnt, es);
        end
      end
      if (e.fl >= 0) begin
        ef = PERF ? 32'(e.fl) : 32'd0;
        checks++;
        if (flushCnt !== ef) begin
          errors++;
          $display("FAIL %s flushCnt: got %0d expected %0d", e.nm, flushCnt, ef);
        end
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic lu, input logic br,
                      input logic mrq, input logic mrdy, input logic mds, input logic mdd,
                      input logic [6:0] ctl, input logic [1:0] st, input logic err,
                      input int stl, input int fl);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; ldUseHaz = lu; branchTaken = br; memReq = mrq;
    memReady = mrdy; mdStart = mds; mdDone = mdd;
    e.nm = nm; e.ctl = ctl; e.st = st; e.err = err; e.stl = stl; e.fl = fl;
    sb_q.push_back(e);
  endtask

  initial begin
    //    name        rst lu br mrq rdy mds mdd  ctl    st   err  stall flush
    step("reset0",    1, 0, 0, 0, 0, 0, 0, RST_C, 2'd0, 1'b0, 0, 0);
    step("reset1",    1, 0, 0, 0, 0, 0, 0, RST_C, 2'd0, 1'b0, 0, 0);
    step("idle",      0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 0, 0);
    step("lduse",     0, 1, 0, 0, 0, 0, 0, LU_C,  2'd0, 1'b0, -1, -1);
    step("lduse_end", 0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 1, 0);
    step("br_lu",     0, 1, 1, 0, 0, 0, 0, BR_C,  2'd0, 1'b0, -1, -1);
    step("br_lu_end", 0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 1, 1);
    step("br",        0, 0, 1, 0, 0, 0, 0, BR_C,  2'd0, 1'b0, -1, -1);
    step("br_end",    0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 1, 2);
    // memReady on the 4th cycle of the request
    step("mem_c1",    0, 0, 0, 1, 0, 0, 0, FRZ_C, 2'd0, 1'b0, -1, -1);
    step("mem_c2",    0, 0, 0, 1, 0, 0, 0, FRZ_C, 2'd1, 1'b0, -1, -1);
    step("mem_c3",    0, 0, 0, 1, 0, 0, 0, FRZ_C, 2'd1, 1'b0, -1, -1);
    step("mem_rdy",   0, 0, 0, 1, 1, 0, 0, RUN_C, 2'd1, 1'b0, -1, -1);
    step("mem_end",   0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 4, 2);
    // memory completes together with a mul/div start; branch ignored when done
    step("mm_c1",     0, 0, 0, 1, 0, 0, 0, FRZ_C, 2'd0, 1'b0, -1, -1);
    step("mm_rdy_md", 0, 0, 0, 1, 1, 1, 0, MD_C,  2'd1, 1'b0, -1, -1);
    step("mm_mdw",    0, 0, 0, 0, 0, 0, 0, MD_C,  2'd2, 1'b0, -1, -1);
    step("mm_done_br",0, 0, 1, 0, 0, 0, 1, RUN_C, 2'd2, 1'b0, -1, -1);
    step("mm_end",    0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 7, 2);
    // mul/div: five bubble cycles then done
    step("md_start",  0, 0, 0, 0, 0, 1, 0, MD_C,  2'd0, 1'b0, -1, -1);
    step("md_w1",     0, 0, 1, 0, 0, 1, 0, MD_C,  2'd2, 1'b0, -1, -1);
    step("md_w2",     0, 0, 0, 1, 0, 0, 0, MD_C,  2'd2, 1'b0, -1, -1);
    step("md_w3",     0, 1, 0, 0, 0, 0, 0, MD_C,  2'd2, 1'b0, -1, -1);
    step("md_w4",     0, 0, 0, 0, 0, 0, 0, MD_C,  2'd2, 1'b0, -1, -1);
    step("md_done",   0, 0, 0, 0, 0, 0, 1, RUN_C, 2'd2, 1'b0, -1, -1);
    step("md_end",    0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 12, 2);
    // memory completion applies branch priority over load-use
    step("mb_c1",     0, 0, 0, 1, 0, 0, 0, FRZ_C, 2'd0, 1'b0, -1, -1);
    step("mb_rdy_br", 0, 1, 1, 1, 1, 0, 0, BR_C,  2'd1, 1'b0, -1, -1);
    step("mb_end",    0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 13, 3);
    // memory stall outranks mdStart in RUN; load-use applies on completion
    step("ml_c1_md",  0, 0, 0, 1, 0, 1, 0, FRZ_C, 2'd0, 1'b0, -1, -1);
    step("ml_rdy_lu", 0, 1, 0, 1, 1, 0, 0, LU_C,  2'd1, 1'b0, -1, -1);
    step("ml_end",    0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 15, 3);
    // timeout: never ready, HALT after the 15th wait cycle
    step("to_c1",     0, 0, 0, 1, 0, 0, 0, FRZ_C, 2'd0, 1'b0, -1, -1);
    for (int i = 1; i <= 15; i++)
      step($sformatf("to_w%0d", i), 0, 0, 0, 1, 0, 0, 0, FRZ_C, 2'd1, 1'b0, -1, -1);
    step("halt1",     0, 0, 1, 1, 1, 0, 1, FRZ_C, 2'd3, 1'b1, 31, 3);
    step("halt2",     0, 1, 0, 0, 0, 1, 0, FRZ_C, 2'd3, 1'b1, 32, 3);
    step("halt_rst",  1, 0, 0, 0, 0, 0, 0, RST_C, 2'd0, 1'b0, 0, 0);
    step("post_rst",  0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 0, 0);
    // memReady in the waitCnt == MEM_TIMEOUT cycle completes normally
    step("bd_c1",     0, 0, 0, 1, 0, 0, 0, FRZ_C, 2'd0, 1'b0, -1, -1);
    for (int i = 1; i <= 14; i++)
      step($sformatf("bd_w%0d", i), 0, 0, 0, 1, 0, 0, 0, FRZ_C, 2'd1, 1'b0, -1, -1);
    step("bd_rdy15",  0, 0, 0, 1, 1, 0, 0, RUN_C, 2'd1, 1'b0, -1, -1);
    step("bd_end",    0, 0, 0, 0, 0, 0, 0, RUN_C, 2'd0, 1'b0, 15, 0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Takes hazard and completion events and drives the pipeline-register write enables and bubble controls. Inputs include the combinational load-use hazard, EX-stage branch redirect, multi-cycle data-memory handshake and multi-cycle mul/div unit. Sits between the hazard/forwarding logic and the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register.

## Interface
- MEM_TIMEOUT, 15: max cycles a data access may wait for memReady before trap (1..2^TO_W-1).
- TO_W, 4: width of memory wait counter.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ldUseHaz  in  1  load-use hazard request (ID/EX load feeding IF/ID operand).
- branchTaken  in  1  EX-stage taken branch/jump; PC mux already selects target.
- memReq  in  1  MEM-stage instruction is a load/store.
- memReady  in  1  data memory completes current access this cycle.
- mdStart  in  1  EX-stage instruction is a multi-cycle mul/div.
- mdDone  in  1  mul/div result valid this cycle.
- PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite  out  1 each  register load enables.
- IF_IDflush, ID_EXflush, EX_MEMflush  out  1 each  load a bubble (NOP, all control 0) instead of data.
- state  out  2  current state (RUN=0, MEMWAIT=1, MDWAIT=2, HALT=3).
- memErr  out  1  sticky memory-timeout flag.
- stallCnt, flushCnt  out  32 each  performance counters (see Configuration).

## Operation
- Outputs are Mealy: combinational from registered state and current inputs; state, wait counter, memErr, counters registered.
- Default (no event): all *write = 1, all *flush = 0.
- RUN, priority high to low, only highest applies:
  1. memReq & !memReady: all four *write = 0; go MEMWAIT, waitCnt = 1.
  2. mdStart: PCwrite = IF_IDwrite = ID_EXwrite = 0, EX_MEMflush = 1; go MDWAIT.
  3. branchTaken: IF_IDflush = ID_EXflush = 1, PCwrite = 1; stay RUN.
  4. ldUseHaz: PCwrite = IF_IDwrite = 0, ID_EXflush = 1; stay RUN.
- branchTaken with ldUseHaz: branch wins; the ID instruction is discarded, so no stall.
- MEMWAIT: memReady = 0 holds all *write = 0 and increments waitCnt. memReady = 1 means outputs follow RUN priorities 2-4, state goes to MDWAIT if mdStart else RUN, and waitCnt clears. waitCnt == MEM_TIMEOUT with memReady = 0 sets memErr and goes to HALT.
- MDWAIT: mdDone = 0 gives PCwrite = IF_IDwrite = ID_EXwrite = 0 and EX_MEMflush = 1. mdDone = 1 gives all *write = 1 (result captured into EX/MEM) and goes to RUN; branchTaken is ignored in MDWAIT (mul/div is not a branch). mdStart is ignored in MDWAIT. memReq cannot stall here because EX/MEM holds a bubble.
- HALT: all *write = 0, all *flush = 0, memErr = 1; leaves only via reset.
- Reset asserted: state = RUN, waitCnt = 0, memErr = 0, counters = 0. All *write = 0 and all *flush = 1 while reset is high, so the pipeline fills with bubbles.

## Timing
- Zero-latency stall/flush: enables respond in the same cycle as the event input.
- State changes on the rising clk after the event.
- Load-use costs exactly 1 bubble; taken branch costs 2 bubbles (IF/ID and ID/EX).
- A memory access with memReady arriving k cycles after first request (k ≤ MEM_TIMEOUT) freezes the pipeline for k cycles.
- Timeout: HALT is entered on the edge after the cycle in which waitCnt == MEM_TIMEOUT and memReady = 0. memReady in that same cycle completes normally.
- Reset deassertion mid-MEMWAIT/MDWAIT: the block restarts in RUN; any outstanding external request is the requester's responsibility.

## Configuration
- PERF_CNT_EN defined: stallCnt increments on every non-reset cycle with PCwrite = 0, including HALT. flushCnt increments on every cycle in which IF_IDflush = 1 due to branchTaken. Both wrap at 2^32 to 0.
- PERF_CNT_EN undefined: stallCnt and flushCnt are ports tied to 0 and no counter flops exist.

## Test plan
- Reset high then release, no events → PCwrite..EX_MEMwrite = 1, flushes 0, state = 0, memErr = 0.
- ldUseHaz = 1 for one cycle → PCwrite = IF_IDwrite = 0 and ID_EXflush = 1 for that cycle only; stallCnt = 1 (PERF_CNT_EN).
- ldUseHaz = 1 and branchTaken = 1 together → IF_IDflush = ID_EXflush = 1, PCwrite = 1, flushCnt = 1.
- memReq = 1, memReady rises on 4th cycle → 3 cycles all *write = 0 with state = 1, then writes = 1, state = 0; stallCnt = 3.
- mdStart = 1, mdDone after 5 cycles → EX_MEMflush = 1 for 5 cycles and state = 2; on the mdDone cycle EX_MEMwrite = 1, then RUN.
- memReq = 1, memReady never, MEM_TIMEOUT = 15 → state = 3 and memErr = 1 after 15 wait cycles. Writes stay 0 until reset, and reset clears to RUN.
